// File: rtl/instruction_decoder_if.sv
// Decode-stage bus: instruction/flag inputs from ROM and ALU, control outputs
// to the register file, the ALU and the program sequencer.
interface instruction_decoder_if;
  logic [7:0] pm_data;
  logic       alu_zero;
  logic [7:0] ir;
  logic       jmp;
  logic       jmp_nz;
  logic [3:0] jmp_addr;
  logic       dont_jmp;
  logic [7:0] reg_en;
  logic [3:0] data_src;
  logic [3:0] imm;
  logic [3:0] alu_func;
  logic       alu_opb_sel;
  logic       halted;

  modport master (
    input  pm_data, alu_zero,
    output ir, jmp, jmp_nz, jmp_addr, dont_jmp, reg_en, data_src,
           imm, alu_func, alu_opb_sel, halted
  );

  modport slave (
    output pm_data, alu_zero,
    input  ir, jmp, jmp_nz, jmp_addr, dont_jmp, reg_en, data_src,
           imm, alu_func, alu_opb_sel, halted
  );
endinterface

// File: rtl/instruction_decoder.sv
// Decode stage: instruction register, zero flag and RESET/RUN(/HALTED) FSM.
// Optional HALT on 0xBF is enabled by defining DECODER_HALT_EN.
module instruction_decoder (
  input  logic                  clk,
  input  logic                  sync_reset,
  instruction_decoder_if.master bus
);

`ifdef DECODER_HALT_EN
  typedef enum logic [1:0] {S_RESET, S_RUN, S_HALTED} state_t;
`else
  typedef enum logic [1:0] {S_RESET, S_RUN} state_t;
`endif

  state_t     state, state_nxt;
  logic [7:0] ir;
  logic       z;
  logic       run;
  logic       is_alu;
  logic [7:0] dec_en;
  logic [3:0] dec_src;
  logic       dec_jmp;
  logic       dec_jnz;

  // IR keeps loading during reset so the word at address 0 is already
  // in IR on the first RUN cycle.
  always_ff @(posedge clk) begin
    ir <= bus.pm_data;
    if (sync_reset) begin
      state <= S_RESET;
      z     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (run && is_alu) z <= bus.alu_zero;
    end
  end

  always_comb begin
    state_nxt = state;
    run       = (state == S_RUN) && !sync_reset;
    is_alu    = (ir[7:5] == 3'b110);
    dec_en    = 8'h00;
    dec_src   = 4'd8;
    dec_jmp   = 1'b0;
    dec_jnz   = 1'b0;

    casez (ir)
      8'b0???????: begin
        dec_en[ir[6:4]] = 1'b1;
        dec_src         = 4'd8;
      end
      8'b10??????: begin
        // Self-move writes nothing: this is the NOP (and 0xBF the HALT).
        if (ir[5:3] != ir[2:0]) dec_en[ir[5:3]] = 1'b1;
        dec_src = {1'b0, ir[2:0]};
      end
      8'b110?????: begin
        dec_en[4] = 1'b1;
        dec_src   = 4'd9;
      end
      8'b1110????: dec_jmp = 1'b1;
      default:     dec_jnz = 1'b1;
    endcase

    case (state)
      S_RESET: state_nxt = S_RUN;
`ifdef DECODER_HALT_EN
      S_RUN:   if (ir == 8'hBF) state_nxt = S_HALTED;
`endif
      default: state_nxt = state;
    endcase
  end

  assign bus.ir          = ir;
  assign bus.reg_en      = run ? dec_en : 8'h00;
  assign bus.jmp         = run & dec_jmp;
  assign bus.jmp_nz      = run & dec_jnz;
  assign bus.jmp_addr    = ir[3:0];
  assign bus.dont_jmp    = z;
  assign bus.data_src    = dec_src;
  assign bus.imm         = ir[3:0];
  assign bus.alu_func    = ir[3:0];
  assign bus.alu_opb_sel = ir[4];
`ifdef DECODER_HALT_EN
  assign bus.halted      = (state == S_HALTED);
`else
  assign bus.halted      = 1'b0;
`endif

endmodule
